// File: rtl/buffer_rx_pack.sv
// buffer_rx_pack: packs four RX FIFO bytes (first byte in [7:0]) into one 32-bit word for the AXI4-Lite read path.
// Optional BUFFER_RX_TIMEOUT_EN flushes a partial word after TIMEOUT_CYCLES idle cycles.
module buffer_rx_pack #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        empty,
    input  logic [7:0]  in_data,
    output logic        rd_en,
    input  logic        rxReady,
    output logic        rxValid,
    output logic [31:0] data_out,
    output logic [2:0]  byte_cnt,
    output logic        partial
);
    localparam logic [2:0] S_BYTE0 = 3'd0;
    localparam logic [2:0] S_BYTE1 = 3'd1;
    localparam logic [2:0] S_BYTE2 = 3'd2;
    localparam logic [2:0] S_BYTE3 = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    if (TMR_W < 1 || TMR_W > 30 || (1 << TMR_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("buffer_rx_pack: 2**TMR_W must exceed TIMEOUT_CYCLES");
    end

    logic [2:0]  state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        partial_q, partial_d;
    logic        collecting, timeout, pop, handshake;

    assign collecting = (state_q <= S_BYTE3);
    assign handshake  = valid_q && rxReady;

`ifdef BUFFER_RX_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timing;

    // timer only runs while a word is partly filled
    assign timing  = (state_q == S_BYTE1) || (state_q == S_BYTE2) || (state_q == S_BYTE3);
    assign timeout = timing && (timer_q == TMR_W'(TIMEOUT_CYCLES));
    assign timer_d = (pop || timeout) ? '0 : (timing && empty) ? timer_q + 1'b1 : timer_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign pop   = rst && !empty && collecting && !timeout;
    assign rd_en = pop;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        if (handshake) begin
            state_d   = S_BYTE0;
            shift_d   = '0;
            valid_d   = 1'b0;
            cnt_d     = 3'd0;
            partial_d = 1'b0;
        end else if (timeout) begin
            data_d    = {8'h00, shift_q};
            valid_d   = 1'b1;
            partial_d = 1'b1;
            state_d   = S_HOLD;
        end else if (pop && state_q == S_BYTE3) begin
            data_d    = {in_data, shift_q};
            valid_d   = 1'b1;
            partial_d = 1'b0;
            cnt_d     = 3'd4;
            state_d   = S_HOLD;
        end else if (pop) begin
            shift_d[{state_q[1:0], 3'b000} +: 8] = in_data;
            cnt_d   = state_q + 3'd1;
            state_d = state_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_BYTE0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= 3'd0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
        end
    end

    assign rxValid  = valid_q;
    assign data_out = data_q;
    assign byte_cnt = cnt_q;
    assign partial  = partial_q;
endmodule

// File: tb/tb_buffer_rx_pack.sv
// tb_buffer_rx_pack: directed vector table plus hand sequences for back-pressure, reset and timeout corners.
module tb_buffer_rx_pack;
`ifdef BUFFER_RX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        rd_en;
    logic        rxReady = 1'b0;
    logic        rxValid;
    logic [31:0] data_out;
    logic [2:0]  byte_cnt;
    logic        partial;

    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic [7:0]  fifo[$];
    logic [35:0] exp_q[$];
    logic        gap = 1'b0;
    logic        vld_seen = 1'b0;
    logic [35:0] held = '0;

    typedef struct {
        logic [7:0]  b[4];
        logic [31:0] w;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;

    buffer_rx_pack #(.TIMEOUT_CYCLES(TO), .TMR_W(11)) dut (
        .clk(clk), .rst(rst), .empty(empty), .in_data(in_data), .rd_en(rd_en),
        .rxReady(rxReady), .rxValid(rxValid), .data_out(data_out),
        .byte_cnt(byte_cnt), .partial(partial)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // one clock: drive FIFO head at negedge, score the word side, pop on the edge
    task automatic cycle();
        logic p;
        @(negedge clk);
        empty   = gap || (fifo.size() == 0);
        in_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
        #1;
        if (rxValid) begin
            if (!vld_seen) begin
                vld_seen = 1'b1;
                held = {partial, byte_cnt, data_out};
                if (exp_q.size() == 0) bad("unexpected_word");
                else chk("word", held, exp_q.pop_front());
            end else begin
                chk("hold_stable", {partial, byte_cnt, data_out}, held);
            end
            chk("rd_en_in_hold", rd_en, 36'd0);
            if (rxReady) vld_seen = 1'b0;
        end else if (vld_seen) begin
            bad("valid_dropped_without_handshake");
            vld_seen = 1'b0;
        end
        p = rd_en;
        @(posedge clk);
        if (p) begin
            void'(fifo.pop_front());
            pops++;
        end
        #1;
    endtask

    task automatic run_until_valid(input string name, input int limit);
        int n;
        n = 0;
        while (!rxValid && n < limit) begin
            cycle();
            n++;
        end
        checks++;
        if (!rxValid) begin
            failures++;
            $display("FAIL %s: rxValid not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        fifo.push_back(b0);
        fifo.push_back(b1);
        fifo.push_back(b2);
        fifo.push_back(b3);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        gap = 1'b0;
        rxReady = 1'b0;
        fifo.delete();
        exp_q.delete();
        vld_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        pops = 0;
    endtask

    initial begin
        int p0;
        int vcount;
        int n;
        logic [7:0] rb[4];
        vt[0].b = '{8'h11, 8'h22, 8'h33, 8'h44}; vt[0].w = 32'h44332211;
        vt[1].b = '{8'h01, 8'h02, 8'h03, 8'h04}; vt[1].w = 32'h04030201;
        vt[2].b = '{8'hFF, 8'h00, 8'hFF, 8'h00}; vt[2].w = 32'h00FF00FF;
        vt[3].b = '{8'h80, 8'h7F, 8'h01, 8'hFE}; vt[3].w = 32'hFE017F80;
        vt[4].b = '{8'h00, 8'h00, 8'h00, 8'h00}; vt[4].w = 32'h00000000;

        // reset state, with FIFO reporting data so rd_en gating is exercised
        empty = 1'b0;
        in_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 36'd0);
        chk("rst_valid", rxValid, 36'd0);
        chk("rst_data", data_out, 36'd0);
        chk("rst_cnt", byte_cnt, 36'd0);
        chk("rst_partial", partial, 36'd0);
        do_reset();

        // first-word latency: valid on the edge consuming the fourth byte
        rxReady = 1'b1;
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        exp_q.push_back({1'b0, 3'd4, 32'h44332211});
        repeat (3) cycle();
        chk("lat_not_yet", rxValid, 36'd0);
        chk("lat_cnt3", byte_cnt, 36'd3);
        cycle();
        chk("lat_valid", rxValid, 36'd1);
        chk("lat_data", data_out, 36'h044332211);
        chk("lat_cnt", byte_cnt, 36'd4);
        chk("lat_pops", pops, 36'd4);
        repeat (3) cycle();
        chk("lat_after_valid", rxValid, 36'd0);
        chk("lat_after_cnt", byte_cnt, 36'd0);
        chk("lat_after_pops", pops, 36'd4);

        for (int i = 0; i < 5; i++) begin
            push4(vt[i].b[0], vt[i].b[1], vt[i].b[2], vt[i].b[3]);
            exp_q.push_back({1'b0, 3'd4, vt[i].w});
            run_until_valid("vec_valid", 20);
            chk("vec_data", data_out, {4'd0, vt[i].w});
            chk("vec_cnt", byte_cnt, 36'd4);
            repeat (2) cycle();
        end

        // back-pressure: first word held, nothing popped, bubble after handshake
        p0 = pops;
        rxReady = 1'b0;
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        push4(8'h05, 8'h06, 8'h07, 8'h08);
        exp_q.push_back({1'b0, 3'd4, 32'h04030201});
        exp_q.push_back({1'b0, 3'd4, 32'h08070605});
        run_until_valid("bp_valid1", 20);
        chk("bp_pops_first", pops - p0, 36'd4);
        repeat (20) cycle();
        chk("bp_pops_held", pops - p0, 36'd4);
        chk("bp_data_held", data_out, 36'h004030201);
        rxReady = 1'b1;
        cycle();
        chk("bp_bubble_valid", rxValid, 36'd0);
        chk("bp_bubble_pops", pops - p0, 36'd4);
        run_until_valid("bp_valid2", 20);
        chk("bp_data2", data_out, 36'h008070605);
        chk("bp_pops_total", pops - p0, 36'd8);
        cycle();

        // random empty gaps and ready stalls, 100 words
        for (int w = 0; w < 100; w++) begin
            for (int k = 0; k < 4; k++) rb[k] = 8'($urandom_range(0, 255));
            push4(rb[0], rb[1], rb[2], rb[3]);
            exp_q.push_back({1'b0, 3'd4, rb[3], rb[2], rb[1], rb[0]});
        end
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            gap = ($urandom_range(0, 2) == 0);
            rxReady = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        gap = 1'b0;
        rxReady = 1'b1;
        repeat (3) cycle();
        chk("rand_words_left", exp_q.size(), 36'd0);
        chk("rand_fifo_left", fifo.size(), 36'd0);
        chk("rand_idle", rxValid, 36'd0);

        // reset mid-word discards 0xAA,0xBB
        do_reset();
        rxReady = 1'b1;
        fifo.push_back(8'hAA);
        fifo.push_back(8'hBB);
        repeat (2) cycle();
        chk("mid_cnt", byte_cnt, 36'd2);
        chk("mid_pops", pops, 36'd2);
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        exp_q.push_back({1'b0, 3'd4, 32'h04030201});
        rst = 1'b0;
        #1;
        chk("mid_rd_en_rst", rd_en, 36'd0);
        repeat (2) cycle();
        chk("mid_pops_rst", pops, 36'd2);
        chk("mid_cnt_rst", byte_cnt, 36'd0);
        chk("mid_valid_rst", rxValid, 36'd0);
        rst = 1'b1;
        run_until_valid("mid_valid", 20);
        chk("mid_data", data_out, 36'h004030201);
        cycle();

`ifdef BUFFER_RX_TIMEOUT_EN
        // timeout flush of 0xDE,0xAD; byte on the timeout cycle is left in the FIFO
        do_reset();
        fifo.push_back(8'hDE);
        fifo.push_back(8'hAD);
        exp_q.push_back({1'b1, 3'd2, 32'h0000ADDE});
        repeat (2) cycle();
        chk("to_pops", pops, 36'd2);
        repeat (16) cycle();
        chk("to_not_early", rxValid, 36'd0);
        fifo.push_back(8'h55);
        cycle();
        chk("to_valid", rxValid, 36'd1);
        chk("to_data", data_out, 36'h00000ADDE);
        chk("to_cnt", byte_cnt, 36'd2);
        chk("to_partial", partial, 36'd1);
        chk("to_no_pop", pops, 36'd2);
        fifo.push_back(8'h66);
        fifo.push_back(8'h77);
        fifo.push_back(8'h88);
        exp_q.push_back({1'b0, 3'd4, 32'h88776655});
        rxReady = 1'b1;
        cycle();
        run_until_valid("to_next_valid", 20);
        chk("to_next_data", data_out, 36'h088776655);
        chk("to_next_partial", partial, 36'd0);
        cycle();
`else
        // without the flush, a partial word waits indefinitely
        do_reset();
        rxReady = 1'b1;
        fifo.push_back(8'hDE);
        fifo.push_back(8'hAD);
        exp_q.push_back({1'b0, 3'd4, 32'h0201ADDE});
        vcount = 0;
        repeat (1000) begin
            cycle();
            if (rxValid) vcount++;
        end
        chk("nto_no_valid", vcount, 36'd0);
        chk("nto_partial", partial, 36'd0);
        chk("nto_cnt", byte_cnt, 36'd2);
        fifo.push_back(8'h01);
        fifo.push_back(8'h02);
        run_until_valid("nto_valid", 20);
        chk("nto_data", data_out, 36'h00201ADDE);
        cycle();
`endif
        chk("end_words_left", exp_q.size(), 36'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/buffer_rx_pack.md
Name: buffer_rx_pack

Overview:
- Receive-side counterpart of the 32-to-8-bit transmit buffer.
- Pops bytes from the UART receive FIFO and packs four consecutive bytes into one 32-bit word for the AXI4-Lite read path.
- Byte order matches the transmit side: first byte received lands in bits [7:0], fourth byte in bits [31:24].
- Sits between the UART RX FIFO (byte side) and the AXI4-Lite register slave (word side).

Parameters:
TIMEOUT_CYCLES, 1024, idle clock cycles before a partial word is flushed (used only with BUFFER_RX_TIMEOUT_EN).
TMR_W, 11, timer width; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  reset, asynchronous, active-low.
empty  in  1  RX FIFO empty flag; a byte is available when low.
in_data  in  8  byte at RX FIFO head.
rd_en  out  1  RX FIFO pop strobe; a byte is consumed on a cycle where rd_en=1.
rxReady  in  1  word-side consumer ready.
rxValid  out  1  data_out holds a complete (or flushed) word.
data_out  out  32  packed word.
byte_cnt  out  3  valid bytes in data_out while rxValid=1 (4 for a full word); otherwise bytes collected so far (0-3).
partial  out  1  word was flushed by timeout; tied 0 without the macro.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low.
- Reset values: state=BYTE0; shift register=0; data_out=0; rxValid=0; byte_cnt=0; partial=0; timer=0.
- rd_en is combinational: rd_en = rst && !empty && (state in BYTE0..BYTE3). It is 0 in HOLD and while rst is low.
- States: BYTE0, BYTE1, BYTE2, BYTE3, HOLD.
- BYTEn with rd_en=1 at the clock edge:
  - shift[8n+7:8n] <= in_data; byte_cnt <= n+1; state <= BYTE(n+1).
  - In BYTE3 the transition is instead: data_out <= {in_data, shift[23:0]}; rxValid <= 1; partial <= 0; byte_cnt <= 4; state <= HOLD.
  - Latency: rxValid rises on the same edge that consumes the fourth byte.
- BYTEn with empty=1: hold state; shift register unchanged.
- HOLD:
  - data_out, byte_cnt and partial are stable while rxValid=1 && rxReady=0.
  - On rxValid && rxReady: rxValid <= 0; partial <= 0; byte_cnt <= 0; shift <= 0; state <= BYTE0.
  - This gives one bubble cycle; the next byte is popped no earlier than the cycle after the handshake.
- rxValid never drops without a handshake, except on reset.
- Back-pressure: no bytes are popped while HOLD persists; the FIFO absorbs incoming data. No byte is dropped or duplicated under any empty/rxReady pattern.
- Reset mid-word: the partial word is discarded and nothing is emitted; the FIFO is not popped during reset.
- No wrap-around states: the byte index never exceeds 3 outside HOLD.

Optional Feature:
Macro: BUFFER_RX_TIMEOUT_EN
- With the macro defined:
  - A TMR_W-bit timer clears on every popped byte and counts only in BYTE1..BYTE3 while empty=1.
  - When the timer reaches TIMEOUT_CYCLES: data_out <= shift register (unfilled upper bytes are 0); byte_cnt <= bytes collected (1-3); partial <= 1; rxValid <= 1; state <= HOLD; timer <= 0.
  - A byte arriving on that same cycle is not popped (rd_en is forced 0 on the timeout cycle). It starts the next word.
  - The timer does not run in BYTE0 or HOLD.
- Without the macro: no timer logic is built; partial is constant 0; a partial word waits indefinitely.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 back-to-back, rxReady=1 -> data_out=0x44332211, byte_cnt=4, rxValid high on the edge consuming 0x44; exactly 4 rd_en pulses.
- Eight bytes 0x01..0x08, rxReady=0 for 20 cycles after the first word -> first word 0x04030201 held stable, rd_en=0 throughout HOLD; after release the second word is 0x08070605.
- FIFO empty toggled randomly between bytes -> the word is correct and state holds during empty gaps; scoreboard matches 100 random words.
- rst pulsed low after 2 bytes (0xAA,0xBB), then bytes 0x01..0x04 -> no word emitted for 0xAA/0xBB; next word is 0x04030201.
- Macro on, TIMEOUT_CYCLES=16: bytes 0xDE,0xAD then empty -> 16 cycles later data_out=0x0000ADDE, byte_cnt=2, partial=1; a byte presented on the timeout cycle is not popped.
- Macro off, same stimulus -> rxValid stays 0 for 1000 cycles; partial=0.
